// File: rtl/mine_spawn_ctrl_pkg.sv
// Shared types and constants for the mine spawn scheduler.
package mine_pkg;

  typedef enum logic [2:0] {
    IDLE_ST,
    WAIT_FRAME_ST,
    AGE_ST,
    SPAWN_CHECK_ST,
    SPAWN_ST
  } state_e;

  localparam int unsigned LFSR_W   = 16;
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned SAMPLE_W = 9;
  localparam int unsigned LIFE_W   = 10;
  localparam int unsigned TIMER_W  = 8;
  localparam int unsigned X_W      = 11;

  // One Galois step: shift right, fold the dropped bit back through the taps.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/mine_spawn_ctrl_if.sv
// Frame/collision side <-> scheduler bundle.
interface mine_spawn_ctrl_if
  import mine_pkg::*;
#(
  parameter int unsigned NUM_MINES = 4
);
  logic                    startOfFrame;
  logic                    enable;
  logic [NUM_MINES-1:0]    killReq;
  logic [NUM_MINES-1:0]    mineActive;
  logic [NUM_MINES-1:0]    mineLoad;
  logic signed [X_W-1:0]   loadX;
  logic                    spawnSkipped;

  // Scheduler view
  modport master (
    input  startOfFrame, enable, killReq,
    output mineActive, mineLoad, loadX, spawnSkipped
  );

  // Frame-sync / collision / mover view
  modport slave (
    output startOfFrame, enable, killReq,
    input  mineActive, mineLoad, loadX, spawnSkipped
  );
endinterface

// File: rtl/mine_spawn_ctrl_lfsr.sv
// 16-bit Galois LFSR, advanced only on request; exposes the low bits used for X.
module mine_lfsr
  import mine_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                step,
  output logic [SAMPLE_W-1:0] sample
);

  logic [LFSR_W-1:0] value;

  // Shift register advance
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)   value <= SEED;
    else if (step) value <= lfsr_next(value);
  end

  assign sample = value[SAMPLE_W-1:0];

endmodule

// File: rtl/mine_spawn_ctrl.sv
// Per-frame mine pool scheduler: ages slots, retires expired mines, spawns periodically.
module mine_spawn_ctrl
  import mine_pkg::*;
#(
  parameter int unsigned       NUM_MINES     = 4,
  parameter int unsigned       SPAWN_PERIOD  = 90,
  parameter int unsigned       MINE_LIFETIME = 300,
  parameter int unsigned       X_MIN         = 32,
  parameter int unsigned       X_MAX         = 448,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetN,
  mine_spawn_ctrl_if.master  bus
);

  localparam int unsigned IDX_W  = (NUM_MINES > 1) ? $clog2(NUM_MINES) : 1;
  localparam int unsigned X_SPAN = X_MAX - X_MIN;
  localparam int unsigned CAND_W = SAMPLE_W + 1;

  state_e                    state_q, state_d;
  logic [NUM_MINES-1:0]      active_q, active_d;
  logic [NUM_MINES-1:0]      load_q, load_d;
  logic                      skipped_q, skipped_d;
  logic signed [X_W-1:0]     loadx_q, loadx_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [IDX_W-1:0]          slot_idx_q, slot_idx_d;
  logic [IDX_W-1:0]          spawn_slot_q, spawn_slot_d;
  logic [LIFE_W-1:0]         life_q [NUM_MINES];
  logic [LIFE_W-1:0]         life_d [NUM_MINES];

  logic                      lfsr_step;
  logic [SAMPLE_W-1:0]       lfsr_sample;
  logic [CAND_W-1:0]         cand;
  logic [X_W-1:0]            spawn_x;
  logic                      free_found;
  logic [IDX_W-1:0]          free_slot;

  mine_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .step   (lfsr_step),
    .sample (lfsr_sample)
  );

  // Fold the 9-bit random sample into [X_MIN, X_MAX] with one conditional subtract
  always_comb begin
    cand = {1'b0, lfsr_sample};
    if (cand > CAND_W'(X_SPAN)) cand = cand - CAND_W'(X_SPAN + 1);
    spawn_x = X_W'(X_MIN) + X_W'(cand);
  end

  // Lowest-index inactive slot
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = NUM_MINES - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_slot  = IDX_W'(i);
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE_ST;
      active_q     <= '0;
      load_q       <= '0;
      skipped_q    <= 1'b0;
      loadx_q      <= $signed(X_W'(X_MIN));
      timer_q      <= TIMER_W'(SPAWN_PERIOD);
      slot_idx_q   <= '0;
      spawn_slot_q <= '0;
      for (int i = 0; i < NUM_MINES; i++) life_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      load_q       <= load_d;
      skipped_q    <= skipped_d;
      loadx_q      <= loadx_d;
      timer_q      <= timer_d;
      slot_idx_q   <= slot_idx_d;
      spawn_slot_q <= spawn_slot_d;
      for (int i = 0; i < NUM_MINES; i++) life_q[i] <= life_d[i];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    load_d       = '0;
    skipped_d    = 1'b0;
    loadx_d      = loadx_q;
    timer_d      = timer_q;
    slot_idx_d   = slot_idx_q;
    spawn_slot_d = spawn_slot_q;
    lfsr_step    = 1'b0;
    for (int i = 0; i < NUM_MINES; i++) life_d[i] = life_q[i];

    case (state_q)
      IDLE_ST: begin
        active_d = '0;
        timer_d  = TIMER_W'(SPAWN_PERIOD);
        state_d  = WAIT_FRAME_ST;
      end
      WAIT_FRAME_ST: begin
        if (bus.startOfFrame) begin
          slot_idx_d = '0;
          lfsr_step  = 1'b1;
          state_d    = AGE_ST;
        end
      end
      AGE_ST: begin
        if (active_q[slot_idx_q]) begin
          life_d[slot_idx_q] = life_q[slot_idx_q] - 1'b1;
          if (life_q[slot_idx_q] == LIFE_W'(1)) active_d[slot_idx_q] = 1'b0;
        end
        if (slot_idx_q == IDX_W'(NUM_MINES - 1)) state_d = SPAWN_CHECK_ST;
        else slot_idx_d = slot_idx_q + 1'b1;
      end
      SPAWN_CHECK_ST: begin
        timer_d = timer_q - 1'b1;
        state_d = WAIT_FRAME_ST;
        if (timer_q == TIMER_W'(1)) begin
          timer_d = TIMER_W'(SPAWN_PERIOD);
          if (free_found) begin
            spawn_slot_d = free_slot;
            state_d      = SPAWN_ST;
          end else begin
            skipped_d = 1'b1;
          end
        end
      end
      SPAWN_ST: state_d = WAIT_FRAME_ST;
      default:  state_d = IDLE_ST;
    endcase

    // Kills land in any state; a spawn on the same slot overrides the kill of the old mine
    active_d = active_d & ~bus.killReq;
    if (state_q == SPAWN_ST) begin
      active_d[spawn_slot_q] = 1'b1;
      life_d[spawn_slot_q]   = LIFE_W'(MINE_LIFETIME);
      load_d[spawn_slot_q]   = 1'b1;
      loadx_d                = $signed(spawn_x);
    end

    if (!bus.enable) begin
      state_d   = IDLE_ST;
      active_d  = '0;
      load_d    = '0;
      skipped_d = 1'b0;
      loadx_d   = loadx_q;
      lfsr_step = 1'b0;
    end
  end

  assign bus.mineActive   = active_q;
  assign bus.mineLoad     = load_q;
  assign bus.loadX        = loadx_q;
  assign bus.spawnSkipped = skipped_q;

endmodule

// File: tb/tb_mine_spawn_ctrl.sv
// Bench for mine_spawn_ctrl: directed frame scenarios plus randomized traffic vs a reference model.
module tb_mine_spawn_ctrl;

  localparam int unsigned N    = 4;
  localparam int unsigned P    = 3;
  localparam int unsigned LT   = 20;
  localparam int          XMIN = 32;
  localparam int          XMAX = 448;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  mine_spawn_ctrl_if #(.NUM_MINES(N)) bus ();

  mine_spawn_ctrl #(
    .NUM_MINES     (N),
    .SPAWN_PERIOD  (P),
    .MINE_LIFETIME (LT),
    .X_MIN         (XMIN),
    .X_MAX         (XMAX),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_seq: -1 waiting for a frame; k in 1..N means the k-th cycle after the frame
  // pulse (ages slot k-1); N+1 is the spawn decision; N+2 is the spawn itself.
  bit          m_run;
  int          m_seq;
  int          m_life [N];
  bit [N-1:0]  m_act;
  int          m_timer;
  int          m_pend;
  logic [15:0] m_lfsr;
  bit [N-1:0]  e_load;
  bit          e_skip;
  int          e_x;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic fb;
    fb = v[0];
    v  = v >> 1;
    if (fb) v = v ^ 16'hB400;
    return v;
  endfunction

  function automatic int x_from(input logic [15:0] v);
    int c;
    c = int'(v[8:0]);
    if (c > XMAX - XMIN) c = c - (XMAX - XMIN + 1);
    return XMIN + c;
  endfunction

  task automatic model_reset();
    m_run   = 1'b0;
    m_seq   = -1;
    m_act   = '0;
    m_timer = P;
    m_pend  = 0;
    m_lfsr  = 16'hACE1;
    e_load  = '0;
    e_skip  = 1'b0;
    e_x     = XMIN;
    for (int i = 0; i < N; i++) m_life[i] = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] nact;
    bit         spawn;
    int         s;
    e_load = '0;
    e_skip = 1'b0;
    if (!bus.enable) begin
      m_run = 1'b0; m_seq = -1; m_act = '0; m_timer = P;
      return;
    end
    if (!m_run) begin
      m_run = 1'b1; m_seq = -1; m_act = '0; m_timer = P;
      return;
    end
    nact  = m_act;
    spawn = (m_seq == N + 2);
    if (m_seq < 0) begin
      if (bus.startOfFrame) begin
        m_lfsr = lfsr_adv(m_lfsr);
        m_seq  = 1;
      end
    end else if (m_seq <= N) begin
      s = m_seq - 1;
      if (m_act[s]) begin
        m_life[s] = m_life[s] - 1;
        if (m_life[s] == 0) nact[s] = 1'b0;
      end
      m_seq++;
    end else if (m_seq == N + 1) begin
      m_timer = m_timer - 1;
      m_seq   = -1;
      if (m_timer == 0) begin
        m_timer = P;
        m_pend  = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_act[i]) m_pend = i;
        if (m_pend < 0) e_skip = 1'b1;
        else m_seq = N + 2;
      end
    end else begin
      m_seq = -1;
    end
    nact = nact & ~bus.killReq;
    if (spawn) begin
      nact[m_pend]   = 1'b1;
      m_life[m_pend] = LT;
      e_load[m_pend] = 1'b1;
      e_x            = x_from(m_lfsr);
    end
    m_act = nact;
  endtask

  // Model advances on the same edge as the DUT
  always @(posedge clk) begin
    if (!resetN) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("mineActive", 32'(bus.mineActive), 32'(m_act));
      check_eq("mineLoad", 32'(bus.mineLoad), 32'(e_load));
      check_eq("spawnSkipped", 32'(bus.spawnSkipped), 32'(e_skip));
      if (e_load != '0) begin
        check_eq("loadX", 32'(bus.loadX), 32'(e_x));
        check_eq("loadX_range", 32'(bus.loadX >= XMIN && bus.loadX <= XMAX), 32'(1));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input logic [N-1:0] kill_at_spawn,
                           output logic [N-1:0] load_seen, output bit skip_seen);
    load_seen = '0;
    skip_seen = 1'b0;
    @(negedge clk) bus.startOfFrame = 1'b1;
    @(negedge clk) bus.startOfFrame = 1'b0;
    for (int k = 1; k <= int'(N) + 6; k++) begin
      if (k == int'(N) + 2) bus.killReq = kill_at_spawn;
      if (k == int'(N) + 3) bus.killReq = '0;
      @(negedge clk);
      load_seen = load_seen | bus.mineLoad;
      skip_seen = skip_seen | bus.spawnSkipped;
    end
  endtask

  function automatic logic [N-1:0] exp_frame_load(input int f);
    case (f)
      3:       return 4'b0001;
      6:       return 4'b0010;
      9:       return 4'b0100;
      12:      return 4'b1000;
      18:      return 4'b0100;
      24:      return 4'b0001;
      27:      return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    logic [N-1:0] ld;
    bit           sk;
    bus.startOfFrame = 1'b0;
    bus.enable       = 1'b0;
    bus.killReq      = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check_eq("rst_mineActive", 32'(bus.mineActive), 32'(0));
    check_eq("rst_mineLoad", 32'(bus.mineLoad), 32'(0));
    check_eq("rst_spawnSkipped", 32'(bus.spawnSkipped), 32'(0));
    check_eq("rst_loadX", 32'(bus.loadX), 32'(XMIN));
    resetN = 1'b1;
    chk_on = 1'b1;

    @(negedge clk) bus.enable = 1'b1;
    repeat (3) @(negedge clk);

    // Pool fill, skip when full, kill, expiry, kill racing a spawn
    for (int f = 1; f <= 30; f++) begin
      run_frame((f == 24) ? 4'b0001 : 4'b0000, ld, sk);
      check_eq($sformatf("frame%0d_load", f), 32'(ld), 32'(exp_frame_load(f)));
      check_eq($sformatf("frame%0d_skip", f), 32'(sk), 32'(f == 15 || f == 21 || f == 30));
      if (f == 3)  check_eq("first_spawn_active", 32'(bus.mineActive), 32'(4'b0001));
      if (f == 15) begin
        check_eq("full_active", 32'(bus.mineActive), 32'(4'b1111));
        @(negedge clk) bus.killReq = 4'b0100;
        @(negedge clk) bus.killReq = '0;
        check_eq("kill_slot2", 32'(bus.mineActive), 32'(4'b1011));
      end
      if (f == 22) check_eq("pre_expiry", 32'(bus.mineActive), 32'(4'b1111));
      if (f == 23) check_eq("expiry_slot0", 32'(bus.mineActive), 32'(4'b1110));
      if (f == 24) check_eq("kill_vs_spawn", 32'(bus.mineActive), 32'(4'b1111));
    end

    // Drop enable in the middle of the aging walk
    @(negedge clk) bus.startOfFrame = 1'b1;
    @(negedge clk) bus.startOfFrame = 1'b0;
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check_eq("disable_clears", 32'(bus.mineActive), 32'(0));
    repeat (2) @(negedge clk);
    check_eq("disabled_idle", 32'(bus.mineActive), 32'(0));
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    for (int f = 1; f <= 3; f++) begin
      run_frame('0, ld, sk);
      check_eq($sformatf("reen_frame%0d_load", f), 32'(ld), 32'((f == 3) ? 4'b0001 : 4'b0000));
    end

    // Randomized frames, kills and enable drops
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.startOfFrame = ($urandom_range(0, 15) == 0);
      bus.killReq      = ($urandom_range(0, 24) == 0) ? N'($urandom) : '0;
      bus.enable       = ($urandom_range(0, 599) != 0);
    end
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.killReq      = '0;
    bus.enable       = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mine_spawn_ctrl.md
# mine_spawn_ctrl

Scheduler for a pool of falling-mine mover instances. Once per video frame it ages every live mine, retires expired ones, and on a fixed frame period launches a new mine into the lowest free slot at a pseudo-random X. Collision logic can kill slots at any time. Sits between the frame-sync generator and the per-slot mover and drawing blocks.

## Interface
- NUM_MINES, 4: number of mine slots/mover instances (1..8)
- SPAWN_PERIOD, 90: frames between spawn attempts (1..255)
- MINE_LIFETIME, 300: frames a mine stays active (1..1023)
- X_MIN, 32: lowest spawn X in pixels
- X_MAX, 448: highest spawn X; X_MAX-X_MIN+1 is in 256..512
- LFSR_SEED, 16'hACE1: non-zero LFSR reset value
- clk  in  1  system clock
- resetN  in  1  reset resetN, asynchronous, active-low; clock clk
- startOfFrame  in  1  one-cycle pulse per frame
- enable  in  1  game running; low freezes and clears the pool
- killReq  in  NUM_MINES  per-slot kill pulse from collision logic
- mineActive  out  NUM_MINES  slot currently live
- mineLoad  out  NUM_MINES  one-cycle pulse: mover of that slot loads loadX and restarts
- loadX  out  11 signed  spawn X, valid while any mineLoad bit is high
- spawnSkipped  out  1  one-cycle pulse: spawn due but no free slot

## Operation
- States: IDLE_ST, WAIT_FRAME_ST, AGE_ST, SPAWN_CHECK_ST, SPAWN_ST.
- IDLE_ST: all mineActive cleared, spawnTimer=SPAWN_PERIOD. Leave to WAIT_FRAME_ST when enable=1.
- WAIT_FRAME_ST: on startOfFrame, slotIdx=0, advance the LFSR one step, go to AGE_ST.
- AGE_ST: one slot per cycle. If the slot is active, lifetime[slotIdx]-1; at 1->0, clear mineActive. After slot NUM_MINES-1, go to SPAWN_CHECK_ST.
- SPAWN_CHECK_ST: spawnTimer-1. If it was 1, reload SPAWN_PERIOD and take the lowest-index inactive slot.
  - Free slot found: go to SPAWN_ST.
  - No free slot: pulse spawnSkipped and go to WAIT_FRAME_ST.
  - Timer not expired: go to WAIT_FRAME_ST.
- SPAWN_ST: for the chosen slot, set mineActive, set lifetime=MINE_LIFETIME and pulse mineLoad. Go to WAIT_FRAME_ST.
- loadX: c = LFSR[8:0]. If c > X_MAX-X_MIN, subtract X_MAX-X_MIN+1 once. loadX = X_MIN + c, always in [X_MIN, X_MAX].
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Steps only in WAIT_FRAME_ST on startOfFrame.
- killReq[i]: clears mineActive[i] on the next edge, in any state.
  - Kill and aging on the same slot in the same cycle: kill wins.
  - Kill and SPAWN_ST on the same slot in the same cycle: spawn wins, because the kill refers to the previous mine.
- enable=0 in any state: go to IDLE_ST next cycle. mineLoad and spawnSkipped are forced low.
- startOfFrame outside WAIT_FRAME_ST is ignored. The sequence takes at most NUM_MINES+3 cycles, far shorter than a frame.

## Timing
- Reset values: state IDLE_ST, mineActive=0, mineLoad=0, spawnSkipped=0, loadX=X_MIN, lifetimes=0, spawnTimer=SPAWN_PERIOD, LFSR=LFSR_SEED.
- All outputs are registered.
- mineLoad rises NUM_MINES+2 cycles after the startOfFrame edge, for one cycle. mineActive for that slot rises on the same edge.
- The first spawn happens on the SPAWN_PERIOD-th frame after enable rises.
- Kill latency: 1 cycle.
- Reset mid-sequence aborts immediately. A pending mineLoad is dropped.

## Structure
- Package mine_pkg holds:
  - state enum
  - LFSR width and tap constant
  - lifetime and timer width localparams (10 and 8 bits)
- Sub-module mine_lfsr: 16-bit Galois LFSR with step input and seed parameter.
- Lifetime counters are a per-slot array inside mine_spawn_ctrl.

## Test plan
- Reset, enable=1, SPAWN_PERIOD=3, 3 frames -> mineLoad[0] pulses NUM_MINES+2 cycles after the 3rd startOfFrame; mineActive=4'b0001; X_MIN ≤ loadX ≤ X_MAX.
- MINE_LIFETIME=5, SPAWN_PERIOD=100 -> mineActive[0] clears during AGE_ST of the 5th frame after the spawn.
- SPAWN_PERIOD=1, NUM_MINES=4, no kills -> slots 0,1,2,3 fill on frames 1–4; frame 5 gives spawnSkipped=1 and no mineLoad.
- All slots full, killReq=4'b0100 -> mineActive=4'b1011 next cycle; next spawn fills slot 2.
- killReq on a slot in the same cycle as its SPAWN_ST -> slot ends active with a fresh lifetime.
- enable dropped mid-AGE_ST -> IDLE_ST next cycle, mineActive=0; re-enable restarts spawnTimer from SPAWN_PERIOD.
